frame_buff_pingpong: RTL and testbench
======================================

Name: frame_buff_pingpong

Overview:
Double-buffered successor of the single-bank camera frame buffer. The camera-capture side writes pixels into one bank while the display side reads the other, so the display never shows a partially written frame. Bank swaps occur only at a display frame boundary, after capture has signalled a complete frame. Image size, stored colour widths, output widths and colour-expansion mode are parameters; read data has a fixed latency and a valid flag.

Parameters:
c_img_cols, 128, image width in pixels
c_img_rows, 128, image height in pixels
c_nb_col, 7, bits of col input
c_nb_row, 7, bits of row input
c_nb_img_pxls, 14, bits of write address (≥ log2(cols*rows))
c_nb_buf_red / c_nb_buf_green / c_nb_buf_blue, 4 / 4 / 4, stored bits per channel; word order {R,G,B}, R in MSBs
c_nb_out_red / c_nb_out_green / c_nb_out_blue, 5 / 5 / 6, output bits per channel; each must be ≥ its stored width
c_expand, 1, 0 = zero-pad MSBs, 1 = MSB bit-replication into the LSBs
c_nb_drop, 8, width of the dropped-frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
wea  in  1  pixel write strobe
addra  in  c_nb_img_pxls  pixel index within the frame (row*cols+col)
dina  in  c_nb_buf  packed pixel
wr_frame_done  in  1  one-cycle pulse: capture finished a frame
rd_en  in  1  read request
row  in  c_nb_row  read row
col  in  c_nb_col  read column
rd_frame_start  in  1  one-cycle pulse at display vsync
r  out  c_nb_out_red  red out
g  out  c_nb_out_green  green out
b  out  c_nb_out_blue  blue out
rd_valid  out  1  r/g/b valid
bank_sel  out  1  bank currently written; display reads !bank_sel
swap_pend  out  1  complete frame waiting for swap
drop_cnt  out  c_nb_drop  frames overwritten before display, saturating

Behaviour:
- Reset: asynchronous, active-high. Clears r, g, b, rd_valid, bank_sel, swap_pend and drop_cnt to 0. Memory contents are undefined after reset and are not cleared.
- Memory: 2*c_img_pxls words of c_nb_buf bits. Physical address = {bank, pixel index}.
- Write path:
  - When wea=1 and addra < c_img_pxls, dina is stored at {bank_sel, addra} on the clock edge.
  - When addra ≥ c_img_pxls, the write is ignored.
- Swap control, evaluated every cycle:
  - wr_frame_done=1 and swap_pend=0: set swap_pend.
  - wr_frame_done=1 and swap_pend=1: drop_cnt increments, saturating at all-ones; swap_pend stays 1.
  - rd_frame_start=1 and (swap_pend=1 or wr_frame_done=1): toggle bank_sel and clear swap_pend; no drop is counted.
  - rd_frame_start=1 with neither pending nor done: no change.
- A write in the same cycle as a swap goes to the old bank_sel.
- Writes after wr_frame_done but before the swap overwrite the pending bank, which is not displayed.
- Read pipeline (latency 2):
  - Cycle N: rd_en, row and col are sampled.
  - Stage 1 (registered at edge N+1): pixel index = row*c_img_cols + col, computed at full width with no truncation. Also registered here: the bank (!bank_sel as of cycle N), an in-range flag (row < c_img_rows and col < c_img_cols), and rd_en.
  - Stage 2 (edge N+2): memory word is read and channels are expanded. rd_valid = stage-1 rd_en.
  - Out-of-range requests produce r = g = b = 0 with rd_valid still 1.
  - When rd_valid=0, r/g/b hold their previous values.
- A bank swap while reads are in flight does not affect them: each read uses the bank latched in stage 1.
- Channel expansion, for a stored width n and output width m:
  - c_expand=0: output = {(m−n) zeros, value}.
  - c_expand=1: output = value repeated from the MSB and truncated to m bits, e.g. 4→5 gives {v, v[3]} and 4→6 gives {v, v[3:2]}.
- Back-to-back rd_en gives one result per cycle with no bubbles.

Test Plan:
- Reset mid-operation: assert rst during a read burst → r/g/b/rd_valid/bank_sel/swap_pend/drop_cnt read 0 immediately, not waiting for a clock edge; reads resume cleanly after release.
- Bank isolation: write 0xA5C at addra=0 (bank 0), pulse wr_frame_done, then rd_frame_start → bank_sel=1. Read row=0, col=0 → two cycles later rd_valid=1, r=5'b10101, g=5'b01010, b=6'b110011 (c_expand=1). A further write of 0x123 to addra=0 does not change the read result.
- Zero-pad mode: c_expand=0, same pixel 0xA5C → r=5'b01010, g=5'b00101, b=6'b001100.
- Drop counting: three wr_frame_done pulses with no rd_frame_start → swap_pend=1, drop_cnt=2. Simultaneous wr_frame_done and rd_frame_start with swap_pend=0 → bank toggles, swap_pend=0, drop_cnt unchanged. Saturation check with c_nb_drop=2: five extra pulses → drop_cnt=3.
- Range and addressing: read row=0, col=128 → rd_valid=1, rgb=0. Write to addra=16384 is ignored. Write at index 127*128+127 is read back at row=127, col=127.
- Streaming and swap-in-flight: rd_en held high for 128 cycles across a row → 128 consecutive rd_valid cycles in order. A swap in the cycle after a request is issued still returns old-bank data for that request.

Source files
------------

// File: rtl/frame_buff_pingpong.sv
// Ping-pong frame buffer: the camera writes one bank while the display reads
// the other. Banks swap only at a display frame start, after capture has
// reported a finished frame. Reads take two cycles and return the stored
// colour channels widened to the output widths.
module frame_buff_pingpong #(
    parameter int c_img_cols     = 128,
    parameter int c_img_rows     = 128,
    parameter int c_nb_col       = 7,
    parameter int c_nb_row       = 7,
    parameter int c_nb_img_pxls  = 14,
    parameter int c_nb_buf_red   = 4,
    parameter int c_nb_buf_green = 4,
    parameter int c_nb_buf_blue  = 4,
    parameter int c_nb_out_red   = 5,
    parameter int c_nb_out_green = 5,
    parameter int c_nb_out_blue  = 6,
    parameter int c_expand       = 1,
    parameter int c_nb_drop      = 8,
    localparam int c_nb_buf      = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wea,
    input  logic [c_nb_img_pxls-1:0]  addra,
    input  logic [c_nb_buf-1:0]       dina,
    input  logic                      wr_frame_done,
    input  logic                      rd_en,
    input  logic [c_nb_row-1:0]       row,
    input  logic [c_nb_col-1:0]       col,
    input  logic                      rd_frame_start,
    output logic [c_nb_out_red-1:0]   r,
    output logic [c_nb_out_green-1:0] g,
    output logic [c_nb_out_blue-1:0]  b,
    output logic                      rd_valid,
    output logic                      bank_sel,
    output logic                      swap_pend,
    output logic [c_nb_drop-1:0]      drop_cnt
);

    localparam int c_img_pxls = c_img_cols * c_img_rows;
    // Wide enough for row*cols + col without losing any carry.
    localparam int c_nb_idx   = c_nb_row + c_nb_col + 1;
    localparam int c_nb_a     = $clog2(c_img_pxls);

    // Widen one channel: zero-pad above the value, or repeat the value from
    // its MSB downwards until the output width is filled.
    function automatic logic [31:0] expand(input logic [31:0] v, input int n, input int m);
        logic [31:0] o;
        o = '0;
        if (c_expand == 0) begin
            o = v;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (i < m) o[5'(m - 1 - i)] = v[5'(n - 1 - (i % n))];
            end
        end
        return o;
    endfunction

    logic [c_nb_buf-1:0] mem [2][c_img_pxls];

    logic                wr_in_rng;
    logic                vld_p1;
    logic                bank_p1;
    logic                inrng_p1;
    logic [c_nb_idx-1:0] idx_p1;
    logic [c_nb_buf-1:0] word_p1;

    assign wr_in_rng = 32'(addra) < 32'(c_img_pxls);

    // Capture side writes into the bank it currently owns; out-of-frame
    // indices are dropped rather than aliased onto a valid pixel.
    always_ff @(posedge clk) begin
        if (wea && wr_in_rng) mem[bank_sel][addra[c_nb_a-1:0]] <= dina;
    end

    // Swap control: a finished frame waits in swap_pend until the display
    // starts a frame; further finished frames meanwhile count as dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel  <= 1'b0;
            swap_pend <= 1'b0;
            drop_cnt  <= '0;
        end else if (rd_frame_start && (swap_pend || wr_frame_done)) begin
            bank_sel  <= ~bank_sel;
            swap_pend <= 1'b0;
        end else if (wr_frame_done) begin
            if (!swap_pend) swap_pend <= 1'b1;
            else if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Stage 1 control: request valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= rd_en;
    end

    // Stage 1 data: pixel index, display bank and range flag. Latching the
    // bank here keeps in-flight reads on their bank across a swap.
    always_ff @(posedge clk) begin
        idx_p1   <= c_nb_idx'(row) * c_nb_idx'(c_img_cols) + c_nb_idx'(col);
        bank_p1  <= ~bank_sel;
        inrng_p1 <= (32'(row) < 32'(c_img_rows)) && (32'(col) < 32'(c_img_cols));
    end

    // Memory word for the stage-1 request; out-of-range requests read as 0.
    always_comb begin
        word_p1 = '0;
        if (inrng_p1 && (32'(idx_p1) < 32'(c_img_pxls)))
            word_p1 = mem[bank_p1][idx_p1[c_nb_a-1:0]];
    end

    // Stage 2: expanded colour outputs, held while no read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r        <= '0;
            g        <= '0;
            b        <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= vld_p1;
            if (vld_p1) begin
                r <= c_nb_out_red'(expand(32'(word_p1[c_nb_buf-1 -: c_nb_buf_red]),
                                          c_nb_buf_red, c_nb_out_red));
                g <= c_nb_out_green'(expand(32'(word_p1[c_nb_buf_blue +: c_nb_buf_green]),
                                            c_nb_buf_green, c_nb_out_green));
                b <= c_nb_out_blue'(expand(32'(word_p1[c_nb_buf_blue-1:0]),
                                           c_nb_buf_blue, c_nb_out_blue));
            end
        end
    end

endmodule

// File: tb/tb_frame_buff_pingpong.sv
// Bench for frame_buff_pingpong: two instances (replicating expansion with an
// 8-bit drop counter, zero-padding with a 2-bit drop counter) share stimulus.
// Row/col inputs are widened to 8 bits so out-of-range columns can be driven.
module tb_frame_buff_pingpong;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wea = 1'b0;
    logic [14:0] addra = '0;
    logic [11:0] dina = '0;
    logic        wr_frame_done = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  row = '0;
    logic [7:0]  col = '0;
    logic        rd_frame_start = 1'b0;

    logic [4:0]  r, g, rz, gz;
    logic [5:0]  b, bz;
    logic        rd_valid, bank_sel, swap_pend;
    logic        rd_valid_z, bank_sel_z, swap_pend_z;
    logic [7:0]  drop_cnt;
    logic [1:0]  drop_cnt_z;

    int n_chk  = 0;
    int n_pass = 0;
    int run    = 0;
    int max_run = 0;

    typedef struct packed {
        logic        inr;
        logic [11:0] w;
    } sb_t;
    sb_t sbq[$];

    logic        m_bank, m_pend;
    logic [7:0]  m_drop;
    logic [1:0]  m_drop_z;
    logic [11:0] mmem [2][16384];

    always #5 clk = ~clk;

    frame_buff_pingpong #(.c_nb_col(8), .c_nb_row(8), .c_nb_img_pxls(15),
                          .c_expand(1), .c_nb_drop(8)) dut (
        .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina),
        .wr_frame_done(wr_frame_done), .rd_en(rd_en), .row(row), .col(col),
        .rd_frame_start(rd_frame_start), .r(r), .g(g), .b(b),
        .rd_valid(rd_valid), .bank_sel(bank_sel), .swap_pend(swap_pend),
        .drop_cnt(drop_cnt)
    );

    frame_buff_pingpong #(.c_nb_col(8), .c_nb_row(8), .c_nb_img_pxls(15),
                          .c_expand(0), .c_nb_drop(2)) dut_z (
        .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina),
        .wr_frame_done(wr_frame_done), .rd_en(rd_en), .row(row), .col(col),
        .rd_frame_start(rd_frame_start), .r(rz), .g(gz), .b(bz),
        .rd_valid(rd_valid_z), .bank_sel(bank_sel_z), .swap_pend(swap_pend_z),
        .drop_cnt(drop_cnt_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference model: bank/swap state, memory image, and expected reads.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bank   <= 1'b0;
            m_pend   <= 1'b0;
            m_drop   <= '0;
            m_drop_z <= '0;
            sbq.delete();
        end else begin
            if (rd_en) begin
                if (row < 8'd128 && col < 8'd128)
                    sbq.push_back(sb_t'{1'b1, mmem[~m_bank][14'({row[6:0], col[6:0]})]});
                else
                    sbq.push_back(sb_t'{1'b0, 12'h000});
            end
            if (wea && addra < 15'd16384) mmem[m_bank][addra[13:0]] <= dina;
            if (rd_frame_start && (m_pend || wr_frame_done)) begin
                m_bank <= ~m_bank;
                m_pend <= 1'b0;
            end else if (wr_frame_done) begin
                if (!m_pend) m_pend <= 1'b1;
                else begin
                    if (m_drop != 8'hFF) m_drop <= m_drop + 8'd1;
                    if (m_drop_z != 2'h3) m_drop_z <= m_drop_z + 2'd1;
                end
            end
        end
    end

    // Output monitor: every valid result is matched against the queue head.
    always @(posedge clk) begin
        sb_t it;
        #1;
        if (!rst) begin
            run = rd_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (rd_valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected", 32'(sbq.size()), 32'd1);
                end else begin
                    it = sbq.pop_front();
                    chk("sb_r",  32'(r),  32'({it.w[11:8], it.w[11]}));
                    chk("sb_g",  32'(g),  32'({it.w[7:4], it.w[7]}));
                    chk("sb_b",  32'(b),  32'({it.w[3:0], it.w[3:2]}));
                    chk("sb_rz", 32'(rz), 32'({1'b0, it.w[11:8]}));
                    chk("sb_gz", 32'(gz), 32'({1'b0, it.w[7:4]}));
                    chk("sb_bz", 32'(bz), 32'({2'b0, it.w[3:0]}));
                    chk("sb_vz", 32'(rd_valid_z), 32'd1);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [11:0] d);
        @(negedge clk);
        wea = 1'b1; addra = 15'(a); dina = d;
        @(negedge clk);
        wea = 1'b0;
    endtask

    task automatic pulse(input logic done, input logic start);
        @(negedge clk);
        wr_frame_done = done; rd_frame_start = start;
        @(negedge clk);
        wr_frame_done = 1'b0; rd_frame_start = 1'b0;
    endtask

    task automatic rd(input int rr, input int cc);
        @(negedge clk);
        rd_en = 1'b1; row = 8'(rr); col = 8'(cc);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic bs, input logic sp,
                             input logic [7:0] dc, input logic [1:0] dcz);
        chk({tag, "_bank"}, 32'(bank_sel), 32'(bs));
        chk({tag, "_pend"}, 32'(swap_pend), 32'(sp));
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(dc));
        chk({tag, "_bank_z"}, 32'(bank_sel_z), 32'(bs));
        chk({tag, "_drop_z"}, 32'(drop_cnt_z), 32'(dcz));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_r"}, 32'(r), 0);
        chk({tag, "_g"}, 32'(g), 0);
        chk({tag, "_b"}, 32'(b), 0);
        chk({tag, "_rz"}, 32'(rz), 0);
        chk({tag, "_valid"}, 32'(rd_valid), 0);
        chk({tag, "_valid_z"}, 32'(rd_valid_z), 0);
        chk_state(tag, 1'b0, 1'b0, 8'd0, 2'd0);
    endtask

    initial begin
        // Reset state, seen before any clock edge.
        #2 rst = 1'b1;
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Bank isolation and both expansion modes.
        wr(0, 12'hA5C);
        pulse(1'b1, 1'b0);
        chk_state("pend1", 1'b0, 1'b1, 8'd0, 2'd0);
        pulse(1'b0, 1'b1);
        chk_state("swap1", 1'b1, 1'b0, 8'd0, 2'd0);
        rd(0, 0);
        idle(1);
        chk("iso_valid", 32'(rd_valid), 1);
        chk("iso_r", 32'(r), 32'(5'b10101));
        chk("iso_g", 32'(g), 32'(5'b01010));
        chk("iso_b", 32'(b), 32'(6'b110011));
        chk("zp_r", 32'(rz), 32'(5'b01010));
        chk("zp_g", 32'(gz), 32'(5'b00101));
        chk("zp_b", 32'(bz), 32'(6'b001100));
        wr(0, 12'h123);
        rd(0, 0);
        idle(1);
        chk("iso2_r", 32'(r), 32'(5'b10101));
        chk("iso2_b", 32'(b), 32'(6'b110011));

        // Drop counting, simultaneous done/start, saturation.
        repeat (3) pulse(1'b1, 1'b0);
        chk_state("drop3", 1'b1, 1'b1, 8'd2, 2'd2);
        pulse(1'b0, 1'b1);
        chk_state("swap2", 1'b0, 1'b0, 8'd2, 2'd2);
        pulse(1'b1, 1'b1);
        chk_state("both", 1'b1, 1'b0, 8'd2, 2'd2);
        repeat (5) pulse(1'b1, 1'b0);
        chk_state("sat", 1'b1, 1'b1, 8'd6, 2'd3);
        pulse(1'b0, 1'b1);
        chk_state("swap3", 1'b0, 1'b0, 8'd6, 2'd3);

        // Fill bank 0: corners, in-flight pixel, a row for streaming, and a
        // write past the frame that must not alias onto pixel 0.
        wr(0, 12'h3C7);
        wr(5, 12'h0E1);
        wr(127 * 128 + 127, 12'h5A1);
        wr(16384, 12'hFFF);
        for (int c = 0; c < 128; c++) wr(128 + c, 12'(c * 37 + 5));
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk_state("swap4", 1'b1, 1'b0, 8'd6, 2'd3);

        rd(0, 128);
        idle(1);
        chk("oor_valid", 32'(rd_valid), 1);
        chk("oor_r", 32'(r), 0);
        chk("oor_g", 32'(g), 0);
        chk("oor_b", 32'(b), 0);
        rd(128, 0);
        rd(200, 200);
        rd(0, 0);
        idle(1);
        chk("ignored_wr_rz", 32'(rz), 32'h03);
        rd(127, 127);
        idle(1);
        chk("corner_rz", 32'(rz), 32'h05);
        chk("corner_bz", 32'(bz), 32'h01);

        // Streaming one row with rd_en held high.
        idle(2);
        max_run = 0;
        @(negedge clk);
        rd_en = 1'b1; row = 8'd1; col = 8'd0;
        for (int c = 1; c < 128; c++) begin
            @(negedge clk);
            col = 8'(c);
        end
        @(negedge clk);
        rd_en = 1'b0;
        idle(4);
        chk("stream_run", 32'(max_run), 32'd128);

        // Swap in the cycle after a request: the request keeps bank 0.
        wr(5, 12'h777);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        rd_en = 1'b1; row = 8'd0; col = 8'd5;
        @(negedge clk);
        rd_en = 1'b0; rd_frame_start = 1'b1;
        @(negedge clk);
        rd_frame_start = 1'b0;
        chk("inflight_valid", 32'(rd_valid), 1);
        chk("inflight_g", 32'(g), 32'(5'b11101));
        chk("inflight_bank", 32'(bank_sel), 0);
        idle(2);
        chk("hold_g", 32'(g), 32'(5'b11101));
        rd(0, 5);
        idle(1);
        chk("newbank_g", 32'(g), 32'(5'b01110));

        // Reset in the middle of a read burst, then resume.
        @(negedge clk);
        rd_en = 1'b1; row = 8'd0; col = 8'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            col = (col == 8'd0) ? 8'd5 : 8'd0;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk) col = 8'd5;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            col = (col == 8'd0) ? 8'd5 : 8'd0;
        end
        rd_en = 1'b0;
        idle(2);
        chk("resume_bank", 32'(bank_sel), 0);

        idle(4);
        chk("sb_drain", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
